// File: rtl/mem_stage_ctrl.sv
// Memory stage: pass-through, single load/store to dmem, misalign/illegal/timeout errors.
// Latency: pass-through and error 1 cycle; memory ops ack cycles + 1. Backpressure: in_ready only in IDLE.
module mem_stage_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        MEM_WE,
    input  logic        MEM_REG,
    input  logic        DE_WE,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        in_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        store_q, store_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;

    logic accept, is_store, is_load, is_mem, aligned, mem_go, ack_hit, timeout_hit;

    assign accept      = in_valid & (state_q == S_IDLE);
    assign is_store    = MEM_WE & ~MEM_REG;
    assign is_load     = MEM_REG & ~MEM_WE;
    assign is_mem      = is_store | is_load;
    assign aligned     = (alu_result[1:0] == 2'b00);
    assign mem_go      = accept & is_mem & aligned;
    assign ack_hit     = (state_q == S_REQ) & dmem_ack;
    // Ack in the last counted cycle wins over the timeout.
    assign timeout_hit = (state_q == S_REQ) & ~dmem_ack & (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mem_go) state_d = S_REQ;
            S_REQ:   if (ack_hit || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        store_d    = store_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        err_d      = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (mem_go) begin
            addr_d  = alu_result;
            wdata_d = store_data;
            rd_d    = rd;
            store_d = is_store;
            cnt_d   = 8'd0;
        end else if (accept && !is_mem && !(MEM_WE && MEM_REG)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = DE_WE & (rd != 5'd0);
            wb_rd_d    = rd;
            wb_data_d  = alu_result;
        end else if (accept) begin
            wb_valid_d = 1'b1;
            err_d      = 1'b1;
            wb_rd_d    = rd;
            wb_data_d  = 32'd0;
        end else if (ack_hit) begin
            wb_valid_d = 1'b1;
            wb_we_d    = ~store_q & (rd_q != 5'd0);
            wb_rd_d    = rd_q;
            wb_data_d  = store_q ? 32'd0 : dmem_rdata;
        end else if (timeout_hit) begin
            wb_valid_d = 1'b1;
            err_d      = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = 32'd0;
        end else if (state_q == S_REQ) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            store_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            store_q    <= store_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = (state_q == S_REQ) & store_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, hand sequences, random ops vs a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int ACK_T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, MEM_WE, MEM_REG, DE_WE;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic        in_ready, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    mem_stage_ctrl #(.ACK_TIMEOUT(ACK_T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .MEM_WE(MEM_WE), .MEM_REG(MEM_REG), .DE_WE(DE_WE),
        .alu_result(alu_result), .store_data(store_data), .rd(rd),
        .in_ready(in_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_we;
        logic        mem_reg;
        logic        de_we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sdata;
        int          ack_delay;
        logic [31:0] rdata;
        int          exp_lat;
        int          exp_req;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: what the op should produce, from the classification rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   store = v.mem_we && !v.mem_reg;
        bit   load  = v.mem_reg && !v.mem_we;
        r.exp_err  = 1'b0;
        r.exp_we   = 1'b0;
        r.exp_data = 32'd0;
        r.exp_req  = 0;
        r.exp_lat  = 1;
        if (!store && !load && !(v.mem_we && v.mem_reg)) begin
            r.exp_we   = v.de_we && (v.rd != 0);
            r.exp_data = v.alu;
        end else if ((v.mem_we && v.mem_reg) || (v.alu % 4 != 0)) begin
            r.exp_err = 1'b1;
        end else if (v.ack_delay <= ACK_T) begin
            r.exp_req  = v.ack_delay;
            r.exp_lat  = v.ack_delay + 1;
            r.exp_we   = load && (v.rd != 0);
            r.exp_data = load ? v.rdata : 32'd0;
        end else begin
            r.exp_req = ACK_T;
            r.exp_lat = ACK_T + 1;
            r.exp_err = 1'b1;
        end
        return r;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        int   req_seen = 0;
        int   lat = 0;
        bit   done = 0;
        bit   stable = 1;
        bit   stray_err = 0;
        logic [31:0] a0 = 0, w0 = 0;
        logic        we0 = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; MEM_WE = v.mem_we; MEM_REG = v.mem_reg; DE_WE = v.de_we;
        rd = v.rd; alu_result = v.alu; store_data = v.sdata;
        dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        for (int k = 1; k <= ACK_T + 6 && !done; k++) begin
            @(posedge clk); #1;
            in_valid   = in_ready ? 1'b0 : 1'($urandom % 2);
            MEM_WE     = 1'($urandom % 2);
            MEM_REG    = 1'($urandom % 2);
            DE_WE      = 1'($urandom % 2);
            rd         = 5'($urandom);
            alu_result = $urandom;
            store_data = $urandom;
            if (dmem_req) begin
                dmem_ack   = (req_seen + 1 == v.ack_delay);
                dmem_rdata = dmem_ack ? v.rdata : $urandom;
            end else begin
                dmem_ack   = 1'($urandom % 2);
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            if (dmem_req) begin
                if (req_seen == 0) begin
                    a0 = dmem_addr; we0 = dmem_we; w0 = dmem_wdata;
                    chk({tag, ".dmem_addr"}, dmem_addr, v.alu);
                    chk({tag, ".dmem_we"}, 32'(dmem_we), 32'(v.mem_we && !v.mem_reg));
                    if (v.mem_we) chk({tag, ".dmem_wdata"}, dmem_wdata, v.sdata);
                end else if (dmem_addr !== a0 || dmem_we !== we0 || dmem_wdata !== w0) begin
                    stable = 0;
                end
                req_seen++;
            end
            if (err && !wb_valid) stray_err = 1;
            if (wb_valid) begin
                done = 1;
                lat  = k;
                chk({tag, ".wb_we"}, 32'(wb_we), 32'(v.exp_we));
                chk({tag, ".err"}, 32'(err), 32'(v.exp_err));
                if (!v.exp_err) begin
                    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
                    chk({tag, ".wb_data"}, wb_data, v.exp_data);
                end
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, ".req_cycles"}, 32'(req_seen), 32'(v.exp_req));
        chk({tag, ".req_stable"}, 32'(stable), 32'd1);
        chk({tag, ".stray_err"}, 32'(stray_err), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        chk({tag, ".post_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, ".post_err"}, 32'(err), 32'd0);
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // mem_we mem_reg de_we rd alu sdata ack_delay rdata | lat req we err data
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 32'h0,         0,   32'h0,         1,  0,  1'b1, 1'b0, 32'h0000_1234};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'd0,  32'hCAFE_0001, 32'h0,         0,   32'h0,         1,  0,  1'b0, 1'b0, 32'hCAFE_0001};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0077, 32'h0,         0,   32'h0,         1,  0,  1'b0, 1'b0, 32'h0000_0077};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0100, 32'h0,         3,   32'hDEAD_BEEF, 4,  3,  1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 5'd9,  32'h0000_0200, 32'hA5A5_A5A5, 1,   32'h1234_5678, 2,  1,  1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0102, 32'h0,         1,   32'h0,         1,  0,  1'b0, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd2,  32'h0000_0203, 32'h11,        1,   32'h0,         1,  0,  1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 5'd6,  32'h0000_0400, 32'h22,        1,   32'h0,         1,  0,  1'b0, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0300, 32'h0,         100, 32'h0000_0BAD, 17, 16, 1'b0, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 5'd8,  32'h0000_0304, 32'h0,         16,  32'h0F0F_0F0F, 17, 16, 1'b1, 1'b0, 32'h0F0F_0F0F};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 5'd0,  32'h0000_0308, 32'h0,         2,   32'h1357_9BDF, 3,  2,  1'b0, 1'b0, 32'h1357_9BDF};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_040C, 32'h0000_5A5A, 5,   32'h0000_FFFF, 6,  5,  1'b0, 1'b0, 32'h0};

        rst_n = 1'b1; in_valid = 1'b0; MEM_WE = 1'b0; MEM_REG = 1'b0; DE_WE = 1'b0;
        rd = 5'd0; alu_result = 32'd0; store_data = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.dmem_we", 32'(dmem_we), 32'd0);
        chk("rst.dmem_addr", dmem_addr, 32'd0);
        chk("rst.dmem_wdata", dmem_wdata, 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_we", 32'(wb_we), 32'd0);
        chk("rst.wb_rd", 32'(wb_rd), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back pass-throughs: second op accepted while the first writes back.
        @(posedge clk); #1;
        in_valid = 1'b1; MEM_WE = 1'b0; MEM_REG = 1'b0; DE_WE = 1'b1; rd = 5'd5; alu_result = 32'h1234;
        @(posedge clk); #1;
        rd = 5'd9; alu_result = 32'h55;
        @(negedge clk);
        chk("b2b.in_ready", 32'(in_ready), 32'd1);
        chk("b2b.wb_valid0", 32'(wb_valid), 32'd1);
        chk("b2b.wb_rd0", 32'(wb_rd), 32'd5);
        chk("b2b.wb_data0", wb_data, 32'h1234);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b.wb_valid1", 32'(wb_valid), 32'd1);
        chk("b2b.wb_we1", 32'(wb_we), 32'd1);
        chk("b2b.wb_rd1", 32'(wb_rd), 32'd9);
        chk("b2b.wb_data1", wb_data, 32'h55);
        @(negedge clk);
        chk("b2b.idle", 32'(wb_valid), 32'd0);

        // Reset asserted while a load waits for ack.
        @(posedge clk); #1;
        in_valid = 1'b1; MEM_WE = 1'b0; MEM_REG = 1'b1; DE_WE = 1'b1; rd = 5'd4; alu_result = 32'h500;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstmid.req_before", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.req_now", 32'(dmem_req), 32'd0);
        chk("rstmid.wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("rstmid.in_ready", 32'(in_ready), 32'd1);
        begin
            bit seen = 0;
            dmem_ack = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (wb_valid || dmem_req || err) seen = 1;
            end
            chk("rstmid.no_wb", 32'(seen), 32'd0);
        end

        // Random ops against the model.
        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.mem_we    = 1'($urandom % 2);
            v.mem_reg   = 1'($urandom % 2);
            v.de_we     = 1'($urandom % 2);
            v.rd        = 5'($urandom);
            v.alu       = $urandom;
            if ($urandom % 4 != 0) v.alu[1:0] = 2'b00;
            v.sdata     = $urandom;
            v.ack_delay = $urandom_range(1, ACK_T + 3);
            v.rdata     = $urandom;
            apply(model(v), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
